// File: rtl/ids_t_search_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : ids_t_search_if
// Description : Bundles the table-write port, the search request and the
//               search result of ids_t_search.
//               master - requester side (drives writes, sta, Ids)
//               slave  - ids_t_search side (drives busy and the results)
// Revision    : 1.0 - initial release
// ============================================================================
interface ids_t_search_if #(
  parameter int SINGLE   = 32,
  parameter int INTEGER  = 10,
  parameter int ADDR_Ids = 7
);
  logic                wr_en;
  logic [ADDR_Ids-1:0] wr_addr;
  logic [SINGLE-1:0]   wr_data;
  logic                sta;
  logic [SINGLE-1:0]   Ids;
  logic                busy;
  logic [INTEGER-1:0]  T_int;
  logic [SINGLE-1:0]   Ids_lo;
  logic [SINGLE-1:0]   Ids_hi;
  logic                range_err;
  logic                done_sig;

  modport master (
    output wr_en, wr_addr, wr_data, sta, Ids,
    input  busy, T_int, Ids_lo, Ids_hi, range_err, done_sig
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, sta, Ids,
    output busy, T_int, Ids_lo, Ids_hi, range_err, done_sig
  );
endinterface
`default_nettype wire

// File: rtl/ids_t_search.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : ids_t_search
// Description : Inverse temperature lookup. Holds a 2**ADDR_Ids-entry table
//               of non-negative, non-decreasing IEEE-754 Ids values (entry k
//               is Ids at T = k + T_OFFSET) and binary-searches it for the
//               largest k <= 2**ADDR_Ids-2 with table[k] <= Ids. Returns
//               T_int = k + T_OFFSET plus table[k] and table[k+1] for a
//               downstream interpolator. One search every 9 cycles.
// Ports       : clk        - system clock
//               rst        - asynchronous, active-low reset
//               bus.wr_*   - table write (accepted only while idle)
//               bus.sta    - start pulse, samples bus.Ids
//               bus.busy   - search in progress
//               bus.T_int/Ids_lo/Ids_hi - registered bracket result
//               bus.range_err - Ids outside the table span
//               bus.done_sig  - one-cycle result strobe
// Options     : IDS_TSEARCH_RANGE_ERR_EN - build the below/above detector;
//               when undefined range_err is tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module ids_t_search #(
  parameter int SINGLE   = 32,
  parameter int INTEGER  = 10,
  parameter int ADDR_Ids = 7,
  parameter int T_OFFSET = 273
) (
  input  wire logic     clk,
  input  wire logic     rst,
  ids_t_search_if.slave bus
);

  localparam int                  c_depth   = 1 << ADDR_Ids;
  localparam int                  c_bit_w   = $clog2(ADDR_Ids);
  // The top entry can only ever be the upper half of a bracket.
  localparam logic [ADDR_Ids-1:0] c_top_idx = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t              r_state;
  logic [SINGLE-1:0]   r_table [c_depth];
  logic [SINGLE-1:0]   r_ids;
  logic [ADDR_Ids-1:0] r_k;
  logic [c_bit_w-1:0]  r_bit;
  logic                r_busy;
  logic                r_done;
  logic [INTEGER-1:0]  r_t_int;
  logic [SINGLE-1:0]   r_ids_lo;
  logic [SINGLE-1:0]   r_ids_hi;

  logic [ADDR_Ids-1:0] w_cand;
  logic [ADDR_Ids-1:0] w_k_inc;
  logic                w_take;

  // Successive approximation: try setting the current bit of k and keep it
  // when the candidate entry still does not exceed the key. A negative key
  // (including -0.0) sits below every entry, so nothing is ever taken.
  assign w_cand  = r_k | (ADDR_Ids'(1) << r_bit);
  assign w_k_inc = r_k + ADDR_Ids'(1);
  assign w_take  = (w_cand != c_top_idx) && !r_ids[SINGLE-1] &&
                   (r_table[w_cand][SINGLE-2:0] <= r_ids[SINGLE-2:0]);

  // Table storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (bus.wr_en && (r_state == IDLE)) begin
      r_table[bus.wr_addr] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_ids    <= '0;
      r_k      <= '0;
      r_bit    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_t_int  <= '0;
      r_ids_lo <= '0;
      r_ids_hi <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.sta) begin
            r_ids   <= bus.Ids;
            r_k     <= '0;
            r_bit   <= c_bit_w'(ADDR_Ids - 1);
            r_busy  <= 1'b1;
            r_state <= SEARCH;
          end
        end
        SEARCH: begin
          if (w_take) begin
            r_k <= w_cand;
          end
          if (r_bit == '0) begin
            r_state <= DONE;
          end else begin
            r_bit <= r_bit - c_bit_w'(1);
          end
        end
        DONE: begin
          r_t_int  <= INTEGER'(r_k) + INTEGER'(T_OFFSET);
          r_ids_lo <= r_table[r_k];
          r_ids_hi <= r_table[w_k_inc];
          r_done   <= 1'b1;
          r_busy   <= 1'b0;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef IDS_TSEARCH_RANGE_ERR_EN
  logic r_range_err;
  logic w_below;
  logic w_above;

  assign w_below = r_ids[SINGLE-1] ||
                   (r_ids[SINGLE-2:0] < r_table[0][SINGLE-2:0]);
  assign w_above = !r_ids[SINGLE-1] &&
                   (r_ids[SINGLE-2:0] > r_table[c_depth-1][SINGLE-2:0]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_range_err <= 1'b0;
    end else if (r_state == DONE) begin
      r_range_err <= w_below | w_above;
    end
  end

  assign bus.range_err = r_range_err;
`else
  assign bus.range_err = 1'b0;
`endif

  assign bus.busy     = r_busy;
  assign bus.done_sig = r_done;
  assign bus.T_int    = r_t_int;
  assign bus.Ids_lo   = r_ids_lo;
  assign bus.Ids_hi   = r_ids_hi;

endmodule
`default_nettype wire
